// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types, default sizes and the round-robin pick function for the FIFO
// write-port arbiter (the read side can reuse this package).
package fifo_arb_pkg;

    localparam int unsigned NREQ_DEF    = 4;
    localparam int unsigned DW_DEF      = 8;
    localparam int unsigned MAX_PKT_DEF = 16;
    localparam int unsigned RR_MAX      = 8;
    localparam int unsigned PTR_W       = 3;

    typedef enum logic {
        IDLE,
        XFER
    } arb_state_t;

    // Search upward from last_winner+1 with wrap; unused upper request bits
    // must be zero, so wrapping at RR_MAX gives the same order as at NREQ.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input logic [PTR_W-1:0]  last_winner);
        logic [RR_MAX-1:0] gnt;
        logic [PTR_W-1:0]  idx;
        logic              found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            idx = last_winner + PTR_W'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side beat handshake bus shared by NREQ requesters.
interface fifo_write_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, output req_data, output req_last, input req_ready);
    modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/fifo_write_arbiter_rr_arbiter_core.sv
// Round-robin pick with a registered last-winner pointer; the pointer moves
// only when upd_en is pulsed with the owner that just finished.
module rr_arbiter_core
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            upd_en,
    input  logic [NREQ-1:0] upd_grant,
    output logic [NREQ-1:0] pick
);

    logic [PTR_W-1:0]  last_winner;
    logic [PTR_W-1:0]  upd_idx;
    logic [PTR_W-1:0]  pick_idx;
    logic [RR_MAX-1:0] req_ext;
    logic [RR_MAX-1:0] pick_ext;

    // Fold the full-width one-hot back to an index so the grant is rebuilt
    // at NREQ width for any legal NREQ.
    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
        pick_ext          = rr_pick(req_ext, last_winner);
        pick_idx          = '0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            if (pick_ext[i]) pick_idx = PTR_W'(i);
        end
        pick = (|pick_ext) ? (NREQ'(1) << pick_idx) : '0;
    end

    always_comb begin
        upd_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (upd_grant[i]) upd_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_winner <= PTR_W'(NREQ - 1);
        else if (upd_en) last_winner <= upd_idx;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-locked round-robin arbiter for the write port of a dual-clock FIFO,
// with backpressure on full and a forced release after MAX_PKT beats.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned MAX_PKT = MAX_PKT_DEF,
    parameter int unsigned CW      = $clog2(MAX_PKT)
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_write_arbiter_if.slave   req,
    input  logic                  fifo_full,
    output logic                  fifo_wen,
    output logic [DW-1:0]         fifo_wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  err_len
);

    arb_state_t      state, state_d;
    logic [NREQ-1:0] grant_d, pick, accept;
    logic [CW-1:0]   beat_cnt, beat_cnt_d;
    logic            pkt_done_d, err_len_d, upd_en;
    logic            acc_any, acc_last, at_max;

    assign accept        = (state == XFER && !fifo_full) ? (grant & req.req_valid) : '0;
    assign req.req_ready = (state == XFER && !fifo_full) ? grant : '0;
    assign acc_any       = |accept;
    assign acc_last      = |(accept & req.req_last);
    assign at_max        = (beat_cnt == CW'(MAX_PKT - 1));
    assign fifo_wen      = acc_any;
    assign busy          = (state == XFER);

    always_comb begin
        fifo_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) fifo_wdata = fifo_wdata | req.req_data[i*DW +: DW];
        end
    end

    rr_arbiter_core #(.NREQ(NREQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req.req_valid),
        .upd_en    (upd_en),
        .upd_grant (grant),
        .pick      (pick)
    );

    always_comb begin
        state_d    = state;
        grant_d    = grant;
        beat_cnt_d = beat_cnt;
        pkt_done_d = 1'b0;
        err_len_d  = err_len;
        upd_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req.req_valid) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (acc_any) begin
                    if (acc_last || at_max) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        pkt_done_d = 1'b1;
                        upd_en     = 1'b1;
                        if (!acc_last) err_len_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
            pkt_done <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            beat_cnt <= beat_cnt_d;
            pkt_done <= pkt_done_d;
            err_len  <= err_len_d;
        end
    end

endmodule
